rss_bus_arbiter: RTL and testbench

- Collects completion results from NUM_REQ execution sources (ALUs / reservation-station slots) and serialises them onto the single rss writeback bus. The ROB and reservation stations snoop that bus as dest / value / next_pc.
- Each source has a one-entry holding buffer. A round-robin scheduler picks one buffered result per cycle and drives it on a registered bus.
- The block is flushed by the ROB's mispredict reset.

---
 rtl/rss_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_rss_bus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rss_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rss_bus_arbiter
//  Purpose  : Collects completion results from NUM_REQ execution sources and
//             serialises them onto the single registered rss writeback bus
//             that the ROB and reservation stations snoop. Each source owns a
//             one-entry holding buffer; a round-robin scheduler drains one
//             buffered result per cycle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                 : clock
//    rst                 : asynchronous active-high reset
//    rdy                 : global ready, low pauses accept and broadcast
//    reset_from_rob_bus  : synchronous mispredict flush (overrides rdy)
//    req_valid[i]        : source i presents a result
//    req_ready[i]        : source i buffer empty (straight from a flop)
//    req_dest            : per-source ROB index, slice i at [i*ROB_ID_W +: ROB_ID_W]
//    req_value           : per-source result value
//    req_next_pc         : per-source computed next pc
//    dest_to_rss_bus     : broadcast ROB index, 0 = idle
//    value_to_rss_bus    : broadcast value
//    next_pc_to_rss_bus  : broadcast next pc
//    grant               : one-hot winner of the current broadcast, 0 when idle
// ============================================================================
module rss_bus_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ROB_ID_W = 4,
   parameter int REG_W    = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rdy,
   input  logic                        reset_from_rob_bus,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*ROB_ID_W-1:0] req_dest,
   input  logic [NUM_REQ*REG_W-1:0]    req_value,
   input  logic [NUM_REQ*REG_W-1:0]    req_next_pc,
   output logic [ROB_ID_W-1:0]         dest_to_rss_bus,
   output logic [REG_W-1:0]            value_to_rss_bus,
   output logic [REG_W-1:0]            next_pc_to_rss_bus,
   output logic [NUM_REQ-1:0]          grant
);

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // One extra bit so last + offset never overflows before the wrap.
   localparam int SCAN_W = IDX_W + 1;
   localparam logic [IDX_W-1:0]  C_LAST_RST = IDX_W'(NUM_REQ - 1);
   localparam logic [SCAN_W-1:0] C_NUM_REQ  = SCAN_W'(NUM_REQ);

   // Holding buffers
   logic [NUM_REQ-1:0]                r_buf_valid;
   logic [NUM_REQ-1:0][ROB_ID_W-1:0]  r_buf_dest;
   logic [NUM_REQ-1:0][REG_W-1:0]     r_buf_value;
   logic [NUM_REQ-1:0][REG_W-1:0]     r_buf_next_pc;

   // Round-robin pointer and registered bus
   logic [IDX_W-1:0]    r_last;
   logic [ROB_ID_W-1:0] r_dest;
   logic [REG_W-1:0]    r_value;
   logic [REG_W-1:0]    r_next_pc;
   logic [NUM_REQ-1:0]  r_grant;

   // Arbitration results
   logic                w_win_found;
   logic [IDX_W-1:0]    w_win_idx;
   logic [SCAN_W-1:0]   w_scan;
   logic [NUM_REQ-1:0]  w_win_onehot;
   logic [NUM_REQ-1:0]  w_accept;

   assign req_ready          = ~r_buf_valid;
   assign dest_to_rss_bus    = r_dest;
   assign value_to_rss_bus   = r_value;
   assign next_pc_to_rss_bus = r_next_pc;
   assign grant              = r_grant;

   // Scan last+1, last+2, ... (mod NUM_REQ); the first full buffer wins.
   always_comb begin : p_arb
      w_win_found = 1'b0;
      w_win_idx   = '0;
      w_scan      = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         w_scan = {1'b0, r_last} + SCAN_W'(off);
         if (w_scan >= C_NUM_REQ) begin
            w_scan = w_scan - C_NUM_REQ;
         end
         if (!w_win_found && r_buf_valid[w_scan[IDX_W-1:0]]) begin
            w_win_found = 1'b1;
            w_win_idx   = w_scan[IDX_W-1:0];
         end
      end
   end

   // Winner one-hot and accept qualifiers. A zero ROB index completes the
   // handshake without being stored, since 0 is the bus idle code.
   always_comb begin : p_sel
      w_win_onehot = '0;
      w_accept     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_win_onehot[k] = w_win_found && (w_win_idx == IDX_W'(k));
         w_accept[k]     = req_valid[k] && !r_buf_valid[k] &&
                           (req_dest[k*ROB_ID_W +: ROB_ID_W] != '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin : p_state
      if (rst) begin
         r_buf_valid   <= '0;
         r_buf_dest    <= '0;
         r_buf_value   <= '0;
         r_buf_next_pc <= '0;
         r_last        <= C_LAST_RST;
         r_dest        <= '0;
         r_value       <= '0;
         r_next_pc     <= '0;
         r_grant       <= '0;
      end else if (reset_from_rob_bus) begin
         r_buf_valid   <= '0;
         r_buf_dest    <= '0;
         r_buf_value   <= '0;
         r_buf_next_pc <= '0;
         r_last        <= C_LAST_RST;
         r_dest        <= '0;
         r_value       <= '0;
         r_next_pc     <= '0;
         r_grant       <= '0;
      end else if (!rdy) begin
         // Drop the idle code so the previous result is not rebroadcast.
         r_dest  <= '0;
         r_grant <= '0;
      end else begin
         // A granted buffer was full and an accepted one empty, so the two
         // branches never apply to the same source at one edge.
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_onehot[i]) begin
               r_buf_valid[i] <= 1'b0;
            end else if (w_accept[i]) begin
               r_buf_valid[i]   <= 1'b1;
               r_buf_dest[i]    <= req_dest[i*ROB_ID_W +: ROB_ID_W];
               r_buf_value[i]   <= req_value[i*REG_W +: REG_W];
               r_buf_next_pc[i] <= req_next_pc[i*REG_W +: REG_W];
            end
         end
         if (w_win_found) begin
            r_dest    <= r_buf_dest[w_win_idx];
            r_value   <= r_buf_value[w_win_idx];
            r_next_pc <= r_buf_next_pc[w_win_idx];
            r_grant   <= w_win_onehot;
            r_last    <= w_win_idx;
         end else begin
            r_dest  <= '0;
            r_grant <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rss_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rss_bus_arbiter
//  Purpose  : Self-checking bench for rss_bus_arbiter: a hand-computed
//             vector table, directed multi-cycle sequences, and randomized
//             traffic compared against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rss_bus_arbiter;

   localparam int N  = 4;
   localparam int DW = 4;
   localparam int RW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            rdy;
   logic            flush;
   logic [N-1:0]    valid;
   logic [N*DW-1:0] dests;
   logic [N*RW-1:0] values;
   logic [N*RW-1:0] pcs;
   logic [N-1:0]    ready;
   logic [DW-1:0]   bus_dest;
   logic [RW-1:0]   bus_value;
   logic [RW-1:0]   bus_pc;
   logic [N-1:0]    bus_grant;

   int checks = 0;
   int errors = 0;

   rss_bus_arbiter #(.NUM_REQ(N), .ROB_ID_W(DW), .REG_W(RW)) dut (
      .clk                (clk),
      .rst                (rst),
      .rdy                (rdy),
      .reset_from_rob_bus (flush),
      .req_valid          (valid),
      .req_ready          (ready),
      .req_dest           (dests),
      .req_value          (values),
      .req_next_pc        (pcs),
      .dest_to_rss_bus    (bus_dest),
      .value_to_rss_bus   (bus_value),
      .next_pc_to_rss_bus (bus_pc),
      .grant              (bus_grant)
   );

   always #5 clk = ~clk;

   // Directed payloads are a fixed function of the ROB index (dest 5 gives
   // value 0x1234, next_pc 0x100).
   function automatic logic [31:0] fval(input logic [3:0] d);
      return 32'h0000_122F + {28'd0, d};
   endfunction
   function automatic logic [31:0] fpc(input logic [3:0] d);
      return 32'h0000_00FB + {28'd0, d};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic [3:0] v, input logic [15:0] d);
      rdy   = r;
      flush = f;
      valid = v;
      dests = d;
      for (int i = 0; i < N; i++) begin
         values[i*RW +: RW] = fval(d[i*DW +: DW]);
         pcs[i*RW +: RW]    = fpc(d[i*DW +: DW]);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   bit          m_bv   [N];
   logic [3:0]  m_bd   [N];
   logic [31:0] m_bval [N];
   logic [31:0] m_bpc  [N];
   int          m_last;
   logic [3:0]  m_dest;
   logic [31:0] m_value;
   logic [31:0] m_npc;
   logic [3:0]  m_grant;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_bv[i] = 0; m_bd[i] = '0; m_bval[i] = '0; m_bpc[i] = '0;
      end
      m_last = N - 1; m_dest = '0; m_value = '0; m_npc = '0; m_grant = '0;
   endtask

   task automatic model_edge();
      bit old_bv [N];
      int w;
      if (flush) begin
         model_reset();
      end else if (!rdy) begin
         m_dest  = '0;
         m_grant = '0;
      end else begin
         old_bv = m_bv;
         w = -1;
         for (int off = 1; off <= N; off++) begin
            if (w < 0 && old_bv[(m_last + off) % N]) w = (m_last + off) % N;
         end
         if (w >= 0) begin
            m_dest  = m_bd[w];
            m_value = m_bval[w];
            m_npc   = m_bpc[w];
            m_grant = 4'b0001 << w;
            m_last  = w;
            m_bv[w] = 0;
         end else begin
            m_dest  = '0;
            m_grant = '0;
         end
         for (int i = 0; i < N; i++) begin
            if (!old_bv[i] && valid[i] && dests[i*DW +: DW] != 4'd0) begin
               m_bv[i]   = 1;
               m_bd[i]   = dests[i*DW +: DW];
               m_bval[i] = values[i*RW +: RW];
               m_bpc[i]  = pcs[i*RW +: RW];
            end
         end
      end
   endtask

   function automatic logic [3:0] model_ready();
      logic [3:0] r;
      for (int i = 0; i < N; i++) r[i] = !m_bv[i];
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_model();
      chk("rand_dest",  bus_dest,  m_dest);
      chk("rand_grant", bus_grant, m_grant);
      chk("rand_ready", ready,     model_ready());
      chk("rand_value", bus_value, m_value);
      chk("rand_npc",   bus_pc,    m_npc);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        rdy;
      logic        flush;
      logic [3:0]  valid;
      logic [15:0] dests;
      logic [3:0]  e_dest;
      logic [3:0]  e_grant;
      logic [3:0]  e_ready;
   } vec_t;

   vec_t tbl [16];

   initial begin
      // single source 2, dest-zero drop, flush, then round-robin from source 0
      tbl[0]  = '{1'b1, 1'b0, 4'b0100, 16'h0500, 4'd0, 4'b0000, 4'b1011};
      tbl[1]  = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'd5, 4'b0100, 4'b1111};
      tbl[2]  = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'd0, 4'b0000, 4'b1111};
      tbl[3]  = '{1'b1, 1'b0, 4'b0010, 16'h0000, 4'd0, 4'b0000, 4'b1111};
      tbl[4]  = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'd0, 4'b0000, 4'b1111};
      tbl[5]  = '{1'b1, 1'b1, 4'b0000, 16'h0000, 4'd0, 4'b0000, 4'b1111};
      tbl[6]  = '{1'b1, 1'b0, 4'b1111, 16'h4321, 4'd0, 4'b0000, 4'b0000};
      tbl[7]  = '{1'b1, 1'b0, 4'b1111, 16'h4321, 4'd1, 4'b0001, 4'b0001};
      tbl[8]  = '{1'b1, 1'b0, 4'b1111, 16'h4321, 4'd2, 4'b0010, 4'b0010};
      tbl[9]  = '{1'b1, 1'b0, 4'b1111, 16'h4321, 4'd3, 4'b0100, 4'b0100};
      tbl[10] = '{1'b1, 1'b0, 4'b1111, 16'h4321, 4'd4, 4'b1000, 4'b1000};
      tbl[11] = '{1'b1, 1'b0, 4'b1111, 16'h4321, 4'd1, 4'b0001, 4'b0001};
      tbl[12] = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'd2, 4'b0010, 4'b0011};
      tbl[13] = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'd3, 4'b0100, 4'b0111};
      tbl[14] = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'd4, 4'b1000, 4'b1111};
      tbl[15] = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'd0, 4'b0000, 4'b1111};

      rst = 1'b1;
      drive(1'b1, 1'b0, 4'b0000, 16'h0000);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_dest",  bus_dest,  4'd0);
      chk("reset_grant", bus_grant, 4'b0000);
      chk("reset_ready", ready,     4'b1111);
      rst = 1'b0;

      for (int r = 0; r < 16; r++) begin
         drive(tbl[r].rdy, tbl[r].flush, tbl[r].valid, tbl[r].dests);
         step();
         chk($sformatf("tbl%0d_dest", r),  bus_dest,  tbl[r].e_dest);
         chk($sformatf("tbl%0d_grant", r), bus_grant, tbl[r].e_grant);
         chk($sformatf("tbl%0d_ready", r), ready,     tbl[r].e_ready);
         if (tbl[r].e_dest != 4'd0) begin
            chk($sformatf("tbl%0d_value", r), bus_value, fval(tbl[r].e_dest));
            chk($sformatf("tbl%0d_npc", r),   bus_pc,    fpc(tbl[r].e_dest));
         end
      end

      // Pause: buffers 0 and 1 full, rdy low for 3 cycles while source 2 asks.
      drive(1'b1, 1'b0, 4'b0011, 16'h0021);
      step();
      chk("pause_load_ready", ready, 4'b1100);
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 1'b0, 4'b0111, 16'h0321);
         step();
         chk("pause_dest",  bus_dest,  4'd0);
         chk("pause_grant", bus_grant, 4'b0000);
         chk("pause_ready", ready,     4'b1100);
      end
      drive(1'b1, 1'b0, 4'b0000, 16'h0000);
      step();
      chk("resume_dest0",  bus_dest,  4'd1);
      chk("resume_grant0", bus_grant, 4'b0001);
      chk("resume_value0", bus_value, fval(4'd1));
      step();
      chk("resume_dest1",  bus_dest,  4'd2);
      chk("resume_grant1", bus_grant, 4'b0010);
      step();
      chk("resume_idle",   bus_dest,  4'd0);
      chk("resume_ready",  ready,     4'b1111);

      // Flush: buffers 0,1,3 full, flush while source 2 requests.
      drive(1'b1, 1'b0, 4'b1011, 16'h4021);
      step();
      chk("flush_load_ready", ready, 4'b0100);
      drive(1'b1, 1'b1, 4'b0100, 16'h0300);
      step();
      chk("flush_dest",  bus_dest,  4'd0);
      chk("flush_grant", bus_grant, 4'b0000);
      chk("flush_ready", ready,     4'b1111);
      chk("flush_value", bus_value, 32'd0);
      drive(1'b1, 1'b0, 4'b0000, 16'h0000);
      step();
      chk("flush_drop_dest",  bus_dest, 4'd0);
      chk("flush_drop_ready", ready,    4'b1111);
      drive(1'b1, 1'b0, 4'b1111, 16'h4321);
      step();
      drive(1'b1, 1'b0, 4'b0000, 16'h0000);
      step();
      chk("flush_first_dest",  bus_dest,  4'd1);
      chk("flush_first_grant", bus_grant, 4'b0001);
      repeat (3) step();

      // Asynchronous reset mid-cycle while the bus is busy.
      drive(1'b1, 1'b0, 4'b1101, 16'h4301);
      step();
      drive(1'b1, 1'b0, 4'b0000, 16'h0000);
      step();
      chk("prerst_dest", bus_dest, 4'd1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("arst_dest",  bus_dest,  4'd0);
      chk("arst_grant", bus_grant, 4'b0000);
      chk("arst_ready", ready,     4'b1111);
      @(posedge clk);
      #1;
      chk("arst_hold_ready", ready, 4'b1111);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("postrst_dest",  bus_dest,  4'd0);
         chk("postrst_grant", bus_grant, 4'b0000);
      end

      // Randomized traffic against the reference model.
      for (int c = 0; c < 400; c++) begin
         rdy    = ($urandom_range(0, 9) != 0);
         flush  = ($urandom_range(0, 29) == 0);
         valid  = 4'($urandom);
         dests  = 16'($urandom);
         values = {$urandom, $urandom, $urandom, $urandom};
         pcs    = {$urandom, $urandom, $urandom, $urandom};
         step();
         check_model();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
